// File: rtl/mem_access_pkg.sv
// mem_access_pkg: load/store size codes and controller FSM states
package mem_access_pkg;
  typedef enum logic [2:0] {LD_B = 3'd0, LD_BU = 3'd1, LD_H = 3'd2, LD_HU = 3'd3, LD_W = 3'd4} load_e;
  typedef enum logic [1:0] {ST_B = 2'd0, ST_H = 2'd1, ST_W = 2'd2} store_e;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: request/response handshake plus data-memory strobe bus
interface mem_access_if #(parameter int ADDR_W = 32);
  logic              req_valid, req_ready, req_is_store;
  logic [2:0]        req_load;
  logic [1:0]        req_store;
  logic [31:0]       req_base, req_wdata;
  logic [15:0]       req_offset;
  logic [ADDR_W-1:0] DAddr;
  logic [31:0]       DataIn, MemDataOut, rsp_rdata;
  logic [2:0]        Load;
  logic [1:0]        Store;
  logic              mRD, mWR, rsp_valid, rsp_ready, rsp_misalign;
  modport master (
    input  req_valid, req_is_store, req_load, req_store, req_base, req_offset, req_wdata, MemDataOut, rsp_ready,
    output req_ready, DAddr, DataIn, Load, Store, mRD, mWR, rsp_valid, rsp_rdata, rsp_misalign
  );
  modport slave (
    output req_valid, req_is_store, req_load, req_store, req_base, req_offset, req_wdata, MemDataOut, rsp_ready,
    input  req_ready, DAddr, DataIn, Load, Store, mRD, mWR, rsp_valid, rsp_rdata, rsp_misalign
  );
endinterface

// File: rtl/mem_align_check.sv
// mem_align_check: flags halfword accesses on odd addresses and word accesses off a 4-byte boundary
module mem_align_check
  import mem_access_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic       is_store,
  input  logic [2:0] load,
  input  logic [1:0] store,
  output logic       misalign
);
  logic half, word;
  always_comb begin
    half     = is_store ? (store == ST_H) : (load == LD_H || load == LD_HU);
    word     = is_store ? (store == ST_W) : (load == LD_W);
    misalign = (half & addr_lo[0]) | (word & |addr_lo);
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory initiator with setup/strobe/release sequencing.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned accesses without touching memory.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1,
  parameter int ADDR_W        = 32
) (
  input logic        CLK,
  input logic        RST,
  mem_access_if.master bus
);
  localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d, addr;
  logic [31:0]       datain_q, datain_d, rdata_q, rdata_d;
  logic [2:0]        load_q, load_d;
  logic [1:0]        store_q, store_d;
  logic              st_q, st_d, mrd_q, mrd_d, mwr_q, mwr_d;
  logic              rdy_q, rdy_d, vld_q, vld_d, mis_q, mis_d, misalign;
  assign addr = ADDR_W'(bus.req_base + {{16{bus.req_offset[15]}}, bus.req_offset});
`ifdef MEM_MISALIGN_TRAP_EN
  mem_align_check u_align (
    .addr_lo  (addr[1:0]),
    .is_store (bus.req_is_store),
    .load     (bus.req_load),
    .store    (bus.req_store),
    .misalign (misalign)
  );
`else
  assign misalign = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    daddr_d  = daddr_q;
    datain_d = datain_q;
    load_d   = load_q;
    store_d  = store_q;
    st_d     = st_q;
    rdata_d  = rdata_q;
    rdy_d    = rdy_q;
    vld_d    = vld_q;
    mis_d    = mis_q;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        daddr_d  = addr;
        datain_d = bus.req_wdata;
        load_d   = bus.req_load;
        store_d  = bus.req_store;
        st_d     = bus.req_is_store;
        rdata_d  = '0;
        rdy_d    = 1'b0;
        mis_d    = misalign;
        vld_d    = misalign;
        state_d  = misalign ? RESP : SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CW'(ACCESS_CYCLES - 1);
        mrd_d   = !st_q;
        mwr_d   = st_q;
      end
      ACCESS: if (cnt_q == '0) begin
        state_d = RESP;
        vld_d   = 1'b1;
        rdata_d = st_q ? '0 : bus.MemDataOut;
      end else begin
        cnt_d = cnt_q - 1'b1;
        mrd_d = !st_q;
        mwr_d = st_q;
      end
      RESP: if (bus.rsp_ready) begin
        state_d = IDLE;
        vld_d   = 1'b0;
        mis_d   = 1'b0;
        rdy_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Async reset clears the strobes at once so an interrupted access never completes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      daddr_q  <= '0;
      datain_q <= '0;
      load_q   <= '0;
      store_q  <= '0;
      st_q     <= 1'b0;
      rdata_q  <= '0;
      rdy_q    <= 1'b1;
      vld_q    <= 1'b0;
      mis_q    <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      daddr_q  <= daddr_d;
      datain_q <= datain_d;
      load_q   <= load_d;
      store_q  <= store_d;
      st_q     <= st_d;
      rdata_q  <= rdata_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      mis_q    <= mis_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
    end
  end
  assign bus.req_ready    = rdy_q;
  assign bus.DAddr        = daddr_q;
  assign bus.DataIn       = datain_q;
  assign bus.Load         = load_q;
  assign bus.Store        = store_q;
  assign bus.mRD          = mrd_q;
  assign bus.mWR          = mwr_q;
  assign bus.rsp_valid    = vld_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_misalign = mis_q;
endmodule
